// File: rtl/ysyx_23060203_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_rd_arbiter_if
//   AXI4 read-only channel bundle (AR + R) used between the read arbiter,
//   its two upstream masters and the shared downstream slave.
//
//   Signals:
//     arvalid/arready            read-address handshake
//     araddr/arlen/arsize/arburst read-address payload
//     rvalid/rready              read-data handshake
//     rdata/rresp/rlast          read-data payload
//
//   Modports:
//     master : the side that issues read requests (drives AR, rready)
//     slave  : the side that serves read requests (drives arready, R)
// ---------------------------------------------------------------------------
interface ysyx_23060203_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ysyx_23060203_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_rd_arbiter
//   Two-master, one-slave AXI4 read arbiter. Master 0 is the IFU/ICache,
//   master 1 is the LSU. One read transaction is outstanding at a time; ties
//   are broken round-robin, with master 1 winning the first tie after reset.
//
//   Ports:
//     clock  : single clock, all state on the rising edge
//     reset  : asynchronous, active-low reset
//     m0     : read channel from master 0 (arbiter acts as its slave)
//     m1     : read channel from master 1 (arbiter acts as its slave)
//     s      : read channel to the shared slave (arbiter acts as its master)
//
//   Sequence: IDLE picks a winner (one cycle), ADDR forwards the AR
//   handshake, DATA forwards beats until the rlast handshake, then IDLE.
// ---------------------------------------------------------------------------
module ysyx_23060203_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  ysyx_23060203_rd_arbiter_if.slave      m0,
  ysyx_23060203_rd_arbiter_if.slave      m1,
  ysyx_23060203_rd_arbiter_if.master     s
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  // grant/last encoding: 0 = master 0, 1 = master 1
  logic [1:0]        state_reg,   state_next;
  logic              grant_reg,   grant_next;
  logic              last_reg,    last_next;

  // The forwarded AR channel is fully registered so that no master arvalid
  // or address reaches an output combinationally.
  logic              arvalid_reg, arvalid_next;
  logic [ADDR_W-1:0] araddr_reg,  araddr_next;
  logic [7:0]        arlen_reg,   arlen_next;
  logic [2:0]        arsize_reg,  arsize_next;
  logic [1:0]        arburst_reg, arburst_next;

  logic              in_addr;
  logic              in_data;
  logic              pick;
  logic              sel;
  logic              sel_arvalid;
  logic [ADDR_W-1:0] sel_araddr;
  logic [7:0]        sel_arlen;
  logic [2:0]        sel_arsize;
  logic [1:0]        sel_arburst;
  logic              g_rready;
  logic              ar_hs;
  logic              r_done;

  assign in_addr = (state_reg == ADDR);
  assign in_data = (state_reg == DATA);

  // Round-robin pick in IDLE: a lone requester wins; on a tie the master
  // that was not granted last wins (last_reg resets to 0, so m1 first).
  assign pick = m1.arvalid & (~m0.arvalid | ~last_reg);

  // In IDLE we sample the master about to be granted; afterwards we follow
  // the latched grant.
  assign sel = in_addr ? grant_reg : pick;

  always_comb begin
    sel_arvalid = m0.arvalid;
    sel_araddr  = m0.araddr;
    sel_arlen   = m0.arlen;
    sel_arsize  = m0.arsize;
    sel_arburst = m0.arburst;
    if (sel) begin
      sel_arvalid = m1.arvalid;
      sel_araddr  = m1.araddr;
      sel_arlen   = m1.arlen;
      sel_arsize  = m1.arsize;
      sel_arburst = m1.arburst;
    end
  end

  assign g_rready = grant_reg ? m1.rready : m0.rready;
  assign ar_hs    = in_addr & arvalid_reg & s.arready;
  assign r_done   = in_data & s.rvalid & g_rready & s.rlast;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    last_next    = last_reg;
    arvalid_next = arvalid_reg;
    araddr_next  = araddr_reg;
    arlen_next   = arlen_reg;
    arsize_next  = arsize_reg;
    arburst_next = arburst_reg;

    case (state_reg)
      IDLE: begin
        arvalid_next = 1'b0;
        if (m0.arvalid | m1.arvalid) begin
          state_next   = ADDR;
          grant_next   = pick;
          arvalid_next = 1'b1;
          araddr_next  = sel_araddr;
          arlen_next   = sel_arlen;
          arsize_next  = sel_arsize;
          arburst_next = sel_arburst;
        end
      end

      ADDR: begin
        if (ar_hs) begin
          state_next   = DATA;
          arvalid_next = 1'b0;
        end else begin
          // A compliant master holds arvalid until the handshake. If it
          // withdraws the request anyway we stay here and stop presenting
          // the AR on the following cycle; re-asserting picks it up again.
          arvalid_next = sel_arvalid;
          if (sel_arvalid) begin
            araddr_next  = sel_araddr;
            arlen_next   = sel_arlen;
            arsize_next  = sel_arsize;
            arburst_next = sel_arburst;
          end
        end
      end

      DATA: begin
        // Only the rlast handshake ends the burst; error responses and
        // intermediate beats keep us here regardless of arlen.
        if (r_done) begin
          state_next = IDLE;
          last_next  = grant_reg;
        end
      end

      default: begin
        state_next   = IDLE;
        arvalid_next = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      grant_reg   <= 1'b0;
      last_reg    <= 1'b0;
      arvalid_reg <= 1'b0;
      araddr_reg  <= '0;
      arlen_reg   <= '0;
      arsize_reg  <= '0;
      arburst_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      last_reg    <= last_next;
      arvalid_reg <= arvalid_next;
      araddr_reg  <= araddr_next;
      arlen_reg   <= arlen_next;
      arsize_reg  <= arsize_next;
      arburst_reg <= arburst_next;
    end
  end

  // -------------------------------------------------------------------------
  // Slave-side outputs
  // -------------------------------------------------------------------------
  assign s.arvalid = arvalid_reg;
  assign s.araddr  = araddr_reg;
  assign s.arlen   = arlen_reg;
  assign s.arsize  = arsize_reg;
  assign s.arburst = arburst_reg;
  assign s.rready  = in_data & g_rready;

  // -------------------------------------------------------------------------
  // Master-side outputs. arready is qualified with the registered arvalid so
  // the master's handshake and the slave's handshake always coincide. Data
  // fields of the non-granted master are held at zero.
  // -------------------------------------------------------------------------
  assign m0.arready = in_addr & ~grant_reg & arvalid_reg & s.arready;
  assign m1.arready = in_addr &  grant_reg & arvalid_reg & s.arready;

  assign m0.rvalid  = in_data & ~grant_reg & s.rvalid;
  assign m1.rvalid  = in_data &  grant_reg & s.rvalid;

  assign m0.rdata   = (in_data & ~grant_reg) ? s.rdata : '0;
  assign m0.rresp   = (in_data & ~grant_reg) ? s.rresp : '0;
  assign m0.rlast   = in_data & ~grant_reg & s.rlast;

  assign m1.rdata   = (in_data &  grant_reg) ? s.rdata : '0;
  assign m1.rresp   = (in_data &  grant_reg) ? s.rresp : '0;
  assign m1.rlast   = in_data &  grant_reg & s.rlast;

endmodule

// File: tb/tb_ysyx_23060203_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060203_rd_arbiter
//   Directed scoreboard bench for the two-master read arbiter. Stimulus
//   pushes the expected AR issues and R beats into queues; a monitor pops
//   and compares on every handshake. A behavioural slave returns
//   rdata = araddr + 4*beat with a configurable rresp.
// ---------------------------------------------------------------------------
module tb_ysyx_23060203_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ysyx_23060203_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  ysyx_23060203_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  ysyx_23060203_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  ysyx_23060203_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  beat_t beat_q[$];
  ar_t   ar_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rlast_cyc = 0;
  int ar_gap = 0;
  int beats_seen = 0;
  bit ar_done [2];
  logic [1:0] resp_cfg = 2'b00;
  bit toggle_rready = 1'b0;
  bit rtog = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] resp);
    ar_t a;
    beat_t b;
    a.id = id; a.addr = addr; a.len = len;
    ar_q.push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.data = addr + 32'(4 * i);
      b.resp = resp;
      b.last = (i == int'(len));
      beat_q.push_back(b);
    end
  endtask

  task automatic take_beat(input logic id, input logic [31:0] d, input logic [1:0] r, input logic l);
    beat_t e;
    if (beat_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_beat: got id=%0d data=%0h expected none", id, d);
    end else begin
      e = beat_q.pop_front();
      check("beat_id",   64'(id), 64'(e.id));
      check("beat_data", 64'(d),  64'(e.data));
      check("beat_resp", 64'(r),  64'(e.resp));
      check("beat_last", 64'(l),  64'(e.last));
      $display("beat   id=%0d data=%08h resp=%0d last=%0d", id, d, r, l);
    end
    beats_seen++;
    if (l) rlast_cyc = cyc;
  endtask

  // ---------------- monitor ----------------
  initial begin
    ar_t a;
    logic id;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (m0_if.rvalid || m1_if.rvalid)
          check("rvalid_exclusive", 64'(m0_if.rvalid & m1_if.rvalid), 64'd0);
        if (m0_if.rvalid && m0_if.rready)
          take_beat(1'b0, m0_if.rdata, m0_if.rresp, m0_if.rlast);
        if (m1_if.rvalid && m1_if.rready)
          take_beat(1'b1, m1_if.rdata, m1_if.rresp, m1_if.rlast);
        if (m0_if.arvalid && m0_if.arready) ar_done[0] = 1'b1;
        if (m1_if.arvalid && m1_if.arready) ar_done[1] = 1'b1;
        if (s_if.arvalid && s_if.arready) begin
          id = m1_if.arready;
          ar_gap = cyc - rlast_cyc;
          check("ar_arready_onehot", 64'(m0_if.arready ^ m1_if.arready), 64'd1);
          if (ar_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ar: got addr=%0h expected none", s_if.araddr);
          end else begin
            a = ar_q.pop_front();
            check("ar_id",   64'(id),          64'(a.id));
            check("ar_addr", 64'(s_if.araddr), 64'(a.addr));
            check("ar_len",  64'(s_if.arlen),  64'(a.len));
            $display("ar     id=%0d addr=%08h len=%0d", id, s_if.araddr, s_if.arlen);
          end
        end
      end
    end
  end

  // ---------------- behavioural slave ----------------
  initial begin
    logic        ar_hs, r_hs, busy;
    logic [31:0] a, base;
    logic [7:0]  l, blen, beat;
    busy = 1'b0; base = '0; blen = '0; beat = '0;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;
    s_if.rresp = 2'b00; s_if.rlast = 1'b0;
    forever begin
      @(negedge clock);
      ar_hs = s_if.arvalid & s_if.arready;
      r_hs  = s_if.rvalid & s_if.rready;
      a     = s_if.araddr;
      l     = s_if.arlen;
      @(posedge clock);
      #1;
      if (!reset) begin
        busy = 1'b0;
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
      end else begin
        s_if.arready = 1'b1;
        if (busy && r_hs) begin
          if (beat == blen) begin
            busy = 1'b0; s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
          end else begin
            beat = beat + 8'd1;
          end
        end else if (!busy && ar_hs) begin
          busy = 1'b1; base = a; blen = l; beat = 8'd0;
        end
        if (busy) begin
          s_if.rvalid = 1'b1;
          s_if.rdata  = base + {22'd0, beat, 2'b00};
          s_if.rresp  = resp_cfg;
          s_if.rlast  = (beat == blen);
        end
      end
    end
  end

  // ---------------- master rready drivers ----------------
  initial begin
    m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      rtog = ~rtog;
      m0_if.rready = toggle_rready ? rtog : 1'b1;
      m1_if.rready = toggle_rready ? rtog : 1'b1;
    end
  end

  task automatic req_start(input logic id, input logic [31:0] addr, input logic [7:0] len);
    if (id) begin
      m1_if.arvalid = 1'b1; m1_if.araddr = addr; m1_if.arlen = len;
      m1_if.arsize = 3'd2; m1_if.arburst = 2'b01;
    end else begin
      m0_if.arvalid = 1'b1; m0_if.araddr = addr; m0_if.arlen = len;
      m0_if.arsize = 3'd2; m0_if.arburst = 2'b01;
    end
  endtask

  task automatic req_wait(input logic id);
    int n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!ar_done[id] && n < 80);
    checks++;
    if (!ar_done[id]) begin
      errors++;
      $display("FAIL ar_timeout: master %0d got no arready in %0d cycles, required a handshake", id, n);
    end
    ar_done[id] = 1'b0;
    if (id) m1_if.arvalid = 1'b0; else m0_if.arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((beat_q.size() != 0 || ar_q.size() != 0) && n < 150) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_pending", 64'(beat_q.size() + ar_q.size()), 64'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_arvalid"},  64'(s_if.arvalid),  64'd0);
    check({tag, "_s_rready"},   64'(s_if.rready),   64'd0);
    check({tag, "_s_araddr"},   64'(s_if.araddr),   64'd0);
    check({tag, "_m0_arready"}, 64'(m0_if.arready), 64'd0);
    check({tag, "_m1_arready"}, 64'(m1_if.arready), 64'd0);
    check({tag, "_m0_rvalid"},  64'(m0_if.rvalid),  64'd0);
    check({tag, "_m1_rvalid"},  64'(m1_if.rvalid),  64'd0);
    check({tag, "_m0_rdata"},   64'(m0_if.rdata),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    m0_if.arvalid = 1'b0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0; m0_if.arburst = '0;
    m1_if.arvalid = 1'b0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0; m1_if.arburst = '0;
    ar_done[0] = 1'b0; ar_done[1] = 1'b0;

    #3;
    check_all_zero("reset");
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;

    // Tie after reset: m1 first, then m0; a second tie again goes to m1.
    push_exp(1'b1, 32'h3000_0000, 8'd0, 2'b00);
    push_exp(1'b0, 32'h8000_0100, 8'd0, 2'b00);
    req_start(1'b0, 32'h8000_0100, 8'd0);
    req_start(1'b1, 32'h3000_0000, 8'd0);
    fork
      req_wait(1'b0);
      req_wait(1'b1);
    join
    wait_drain();
    push_exp(1'b1, 32'h3000_0040, 8'd0, 2'b00);
    push_exp(1'b0, 32'h8000_0200, 8'd0, 2'b00);
    req_start(1'b0, 32'h8000_0200, 8'd0);
    req_start(1'b1, 32'h3000_0040, 8'd0);
    fork
      req_wait(1'b0);
      req_wait(1'b1);
    join
    wait_drain();

    // Single request: s_arvalid rises exactly one cycle after m0_arvalid.
    push_exp(1'b0, 32'h8000_0000, 8'd0, 2'b00);
    req_start(1'b0, 32'h8000_0000, 8'd0);
    @(negedge clock);
    check("single_s_arvalid_cycle0", 64'(s_if.arvalid),  64'd0);
    check("single_m0_arready_cycle0", 64'(m0_if.arready), 64'd0);
    @(negedge clock);
    check("single_s_arvalid_cycle1", 64'(s_if.arvalid), 64'd1);
    check("single_s_araddr", 64'(s_if.araddr), 64'h8000_0000);
    req_wait(1'b0);
    wait_drain();
    check("single_idle_s_arvalid", 64'(s_if.arvalid), 64'd0);
    check("single_idle_s_rready",  64'(s_if.rready),  64'd0);

    // Burst of 4 with rready toggling.
    toggle_rready = 1'b1;
    push_exp(1'b0, 32'h8000_1000, 8'd3, 2'b00);
    req_start(1'b0, 32'h8000_1000, 8'd3);
    req_wait(1'b0);
    wait_drain();

    // m1 request during m0 burst: held until rlast, then one IDLE cycle.
    push_exp(1'b0, 32'h8000_2000, 8'd3, 2'b00);
    push_exp(1'b1, 32'h3000_0080, 8'd0, 2'b00);
    req_start(1'b0, 32'h8000_2000, 8'd3);
    req_wait(1'b0);
    req_start(1'b1, 32'h3000_0080, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("held_m1_arready", 64'(m1_if.arready), 64'd0);
    end
    req_wait(1'b1);
    check("rlast_to_ar_gap", 64'(ar_gap), 64'd2);
    wait_drain();
    toggle_rready = 1'b0;

    // Error response passes through to m1.
    resp_cfg = 2'b10;
    push_exp(1'b1, 32'h4000_0000, 8'd0, 2'b10);
    req_start(1'b1, 32'h4000_0000, 8'd0);
    req_wait(1'b1);
    wait_drain();
    resp_cfg = 2'b00;

    // Mid-burst reset during beat 2 of 4.
    begin
      int b0;
      int n;
      push_exp(1'b0, 32'h8000_3000, 8'd3, 2'b00);
      req_start(1'b0, 32'h8000_3000, 8'd3);
      req_wait(1'b0);
      b0 = beats_seen;
      n = 0;
      while (beats_seen < b0 + 1 && n < 50) begin
        @(posedge clock);
        #1;
        n++;
      end
      check("midreset_first_beat_seen", 64'(beats_seen >= b0 + 1), 64'd1);
      #1 reset = 1'b0;
      #1;
      check_all_zero("midreset");
      beat_q.delete();
      ar_q.delete();
      ar_done[0] = 1'b0; ar_done[1] = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      @(posedge clock);
      #1;
      push_exp(1'b1, 32'h3000_00c0, 8'd0, 2'b00);
      push_exp(1'b0, 32'h8000_4000, 8'd0, 2'b00);
      req_start(1'b0, 32'h8000_4000, 8'd0);
      req_start(1'b1, 32'h3000_00c0, 8'd0);
      fork
        req_wait(1'b0);
        req_wait(1'b1);
      join
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
